shift_result_stage: RTL and testbench
=====================================

# shift_result_stage

Registered output stage placed directly downstream of the barrel shifter in the lab ALU datapath. It captures each shifter result together with its operation select and attaches zero and negative flags. It buffers up to two results in a valid/ready skid buffer, so the consumer (display mux or register-file write port) can stall without losing data. It also keeps a saturating count of accepted results for debug.

## Interface
- WIDTH, 8, datapath width; must match the shifter width (≥2)
- CNT_W, 16, width of accepted-result counter

- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- valid_i  in  1  shifter result valid
- ready_o  out  1  stage can accept a result this cycle
- data_i  in  WIDTH  shifter result
- sel_i  in  2  shift operation select that produced data_i; carried opaque
- valid_o  out  1  head entry valid
- ready_i  in  1  consumer accepts head entry this cycle
- data_o  out  WIDTH  head result
- sel_o  out  2  select tag of head entry
- zero_o  out  1  head result == 0
- neg_o  out  1  head result MSB (data[WIDTH-1])
- count_o  out  CNT_W  number of accepted results, saturating

## Operation
- Storage: 2-entry FIFO (head slot + skid slot). Each entry holds {data, sel, zero, neg}. An occupancy register takes the values 0, 1 or 2.
- Flags are computed from data_i at capture time and stored with the entry. They are not recomputed at the output.
- Push = valid_i && ready_o. Pop = valid_o && ready_i.
- ready_o = !rst_i && (occupancy < 2). It is combinational from the registered occupancy only and never depends on ready_i (no combinational ready path).
- valid_o = (occupancy > 0).
- When valid_o=0, data_o, sel_o, zero_o and neg_o are driven 0.
- Occupancy transitions:
  - 0, push: becomes 1; the new entry is the head.
  - 1, push only: becomes 2; the new entry goes to the skid slot.
  - 1, pop only: becomes 0.
  - 1, push+pop: stays 1; the new entry replaces the head.
  - 2, pop: becomes 1; the skid entry moves to the head. No push is possible at 2 because ready_o=0.
  - No push and no pop: all state holds, and output values are stable while valid_o=1 && ready_i=0.
- Ordering is strict FIFO; entries are never dropped or duplicated.
- Counter: count_o increments by 1 on each push and saturates at 2^CNT_W−1. Pops do not affect it.
- valid_i while ready_o=0 is ignored; the upstream must hold valid_i and data_i until accepted.

## Timing
- Latency is 1 cycle: a result pushed at edge N appears on data_o with valid_o=1 after edge N (visible in cycle N+1) when the stage was empty.
- Throughput is 1 result/cycle while ready_i=1.
- Reset (rst_i high at an edge):
  - occupancy becomes 0, valid_o=0, all entry storage is cleared to 0, and count_o=0.
  - ready_o=0 during every cycle rst_i is high, and 1 in the first cycle after deassertion.
- Reset mid-operation discards both buffered entries, with no pop handshake required. A push or pop coinciding with a reset edge has no effect.
- Full boundary: ready_o drops in the cycle after the second push without a pop. It rises in the cycle after the first pop.
- Counter wrap: no wrap. Once at max, count_o holds until reset.

## Test plan
- Single result, WIDTH=8: push data_i=0x80, sel_i=2 with ready_i=1 → next cycle valid_o=1, data_o=0x80, sel_o=2, neg_o=1, zero_o=0. The cycle after, valid_o=0 and outputs are 0.
- Zero flag: push 0x00 → zero_o=1, neg_o=0. Push 0x01 → zero_o=0, neg_o=0.
- Backpressure: ready_i=0, push 0x11, 0x22, 0x33 on consecutive cycles → ready_o=0 after the second push, 0x33 is held upstream, and data_o holds 0x11. Then raise ready_i → output sequence 0x11, 0x22, 0x33 with no gaps, and count_o=3.
- Simultaneous push/pop at occupancy 1: head 0x44 with ready_i=1, push 0x55 in the same cycle → next cycle data_o=0x55, valid_o=1, ready_o=1.
- Reset mid-operation: fill 2 entries, assert rst_i for 1 cycle → valid_o=0, count_o=0, ready_o=0 during reset and 1 after. A subsequent push of 0x66 appears alone.
- Counter saturation (CNT_W=4): perform 20 pushes with ready_i=1 → count_o reaches 15 and stays at 15.

Source files
------------

// File: rtl/shift_result_stage_if.sv
// Handshake bundle between the barrel shifter, the result stage and its consumer.
// Signal names are as seen from the result stage.
interface shift_result_stage_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] data_i;
  logic [1:0]       sel_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] data_o;
  logic [1:0]       sel_o;
  logic             zero_o;
  logic             neg_o;
  logic [CNT_W-1:0] count_o;

  // The result stage.
  modport slave (
    input  valid_i, data_i, sel_i, ready_i,
    output ready_o, valid_o, data_o, sel_o, zero_o, neg_o, count_o
  );

  // Upstream shifter plus downstream consumer.
  modport master (
    output valid_i, data_i, sel_i, ready_i,
    input  ready_o, valid_o, data_o, sel_o, zero_o, neg_o, count_o
  );
endinterface

// File: rtl/shift_result_stage.sv
// Two-entry skid buffer after the barrel shifter: captures result, select and
// zero/negative flags, and keeps a saturating count of accepted results.
module shift_result_stage #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  shift_result_stage_if.slave  bus
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [1:0]       sel;
    logic             zero;
    logic             neg;
  } entry_t;

  logic [1:0]       occ_q, occ_d;
  entry_t           head_q, head_d;
  entry_t           skid_q, skid_d;
  logic [CNT_W-1:0] count_q, count_d;

  entry_t new_entry;
  logic   push, pop;

  // Flags are frozen at capture time so the output path is a plain mux.
  assign new_entry = '{data: bus.data_i,
                       sel:  bus.sel_i,
                       zero: (bus.data_i == '0),
                       neg:  bus.data_i[WIDTH-1]};

  assign bus.ready_o = !rst_i && (occ_q != 2'd2);
  assign bus.valid_o = (occ_q != 2'd0);
  assign push        = bus.valid_i && bus.ready_o;
  assign pop         = bus.valid_o && bus.ready_i;

  // NOTE: every variable gets a hold default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    occ_d   = occ_q;
    head_d  = head_q;
    skid_d  = skid_q;
    count_d = count_q;
    unique case (occ_q)
      2'd0: begin
        if (push) begin
          head_d = new_entry;
          occ_d  = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_d = new_entry;
        end else if (push) begin
          skid_d = new_entry;
          occ_d  = 2'd2;
        end else if (pop) begin
          occ_d  = 2'd0;
        end
      end
      2'd2: begin
        if (pop) begin
          head_d = skid_q;
          occ_d  = 2'd1;
        end
      end
      default: occ_d = 2'd0;
    endcase
    if (push && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // NOTE: entry storage is reset as well, so a reset leaves no stale result behind.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      occ_q   <= 2'd0;
      head_q  <= '0;
      skid_q  <= '0;
      count_q <= '0;
    end else begin
      occ_q   <= occ_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      count_q <= count_d;
    end
  end

  assign bus.data_o  = bus.valid_o ? head_q.data : '0;
  assign bus.sel_o   = bus.valid_o ? head_q.sel  : 2'd0;
  assign bus.zero_o  = bus.valid_o && head_q.zero;
  assign bus.neg_o   = bus.valid_o && head_q.neg;
  assign bus.count_o = count_q;

endmodule

// File: tb/tb_shift_result_stage.sv
// Bench for shift_result_stage: queue-based reference model compared every
// cycle, plus directed vectors with hand-computed expectations.
module tb_shift_result_stage;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  shift_result_stage_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  shift_result_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of accepted results plus an accept count.
  typedef struct {
    logic [WIDTH-1:0] d;
    logic [1:0]       s;
  } item_t;

  item_t m_q[$];
  int    m_cnt = 0;
  bit    m_live = 1'b0;

  always @(posedge clk) begin
    bit m_ready, m_push, m_pop;
    if (rst) begin
      m_q.delete();
      m_cnt  = 0;
      m_live = 1'b1;
    end else if (m_live) begin
      m_ready = (m_q.size() < 2);
      m_push  = bus.valid_i && m_ready;
      m_pop   = (m_q.size() > 0) && bus.ready_i;
      if (m_pop) void'(m_q.pop_front());
      if (m_push) begin
        m_q.push_back('{d: bus.data_i, s: bus.sel_i});
        if (m_cnt < CNT_MAX) m_cnt++;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      logic [WIDTH-1:0] ed;
      logic [1:0]       es;
      ed = (m_q.size() > 0) ? m_q[0].d : '0;
      es = (m_q.size() > 0) ? m_q[0].s : 2'd0;
      check("cmp_ready", bus.ready_o, !rst && (m_q.size() < 2));
      check("cmp_valid", bus.valid_o, m_q.size() > 0);
      check("cmp_data",  bus.data_o,  ed);
      check("cmp_sel",   bus.sel_o,   es);
      check("cmp_zero",  bus.zero_o,  (m_q.size() > 0) && (ed == 0));
      check("cmp_neg",   bus.neg_o,   ed[WIDTH-1]);
      check("cmp_count", bus.count_o, m_cnt);
    end
  end

  task automatic step(input logic v, input logic [7:0] d, input logic [1:0] s, input logic r);
    bus.valid_i = v;
    bus.data_i  = d;
    bus.sel_i   = s;
    bus.ready_i = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 8'h00, 2'd0, 1'b0);
    check("rst_ready_low", bus.ready_o, 1'b0);
    check("rst_valid_low", bus.valid_o, 1'b0);
    rst = 1'b0;
    #1;
    check("rst_ready_after", bus.ready_o, 1'b1);
    check("rst_count_zero", bus.count_o, 0);
  endtask

  initial begin
    bus.valid_i = 1'b0;
    bus.data_i  = '0;
    bus.sel_i   = '0;
    bus.ready_i = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Single result with MSB set, then drained.
    step(1'b1, 8'h80, 2'd2, 1'b1);
    check("single_valid", bus.valid_o, 1'b1);
    check("single_data", bus.data_o, 8'h80);
    check("single_sel", bus.sel_o, 2'd2);
    check("single_neg", bus.neg_o, 1'b1);
    check("single_zero", bus.zero_o, 1'b0);
    step(1'b0, 8'h00, 2'd0, 1'b1);
    check("single_drained_valid", bus.valid_o, 1'b0);
    check("single_drained_data", bus.data_o, 8'h00);
    check("single_drained_sel", bus.sel_o, 2'd0);

    // Zero flag, then 0x01 replacing the head in a push+pop cycle.
    step(1'b1, 8'h00, 2'd1, 1'b1);
    check("zero_flag", bus.zero_o, 1'b1);
    check("zero_neg", bus.neg_o, 1'b0);
    step(1'b1, 8'h01, 2'd3, 1'b1);
    check("one_data", bus.data_o, 8'h01);
    check("one_zero", bus.zero_o, 1'b0);
    check("one_neg", bus.neg_o, 1'b0);
    step(1'b0, 8'h00, 2'd0, 1'b1);

    // Backpressure: third result is held upstream until space opens.
    do_reset();
    step(1'b1, 8'h11, 2'd0, 1'b0);
    check("bp_ready_one", bus.ready_o, 1'b1);
    step(1'b1, 8'h22, 2'd1, 1'b0);
    check("bp_ready_full", bus.ready_o, 1'b0);
    check("bp_head_hold", bus.data_o, 8'h11);
    step(1'b1, 8'h33, 2'd2, 1'b0);
    check("bp_still_full", bus.ready_o, 1'b0);
    check("bp_head_still", bus.data_o, 8'h11);
    check("bp_count_two", bus.count_o, 2);
    step(1'b1, 8'h33, 2'd2, 1'b1);
    check("bp_out_22", bus.data_o, 8'h22);
    check("bp_ready_rise", bus.ready_o, 1'b1);
    step(1'b1, 8'h33, 2'd2, 1'b1);
    check("bp_out_33", bus.data_o, 8'h33);
    check("bp_sel_33", bus.sel_o, 2'd2);
    check("bp_count_three", bus.count_o, 3);
    step(1'b0, 8'h00, 2'd0, 1'b1);
    check("bp_empty", bus.valid_o, 1'b0);

    // Simultaneous push and pop at occupancy 1.
    step(1'b1, 8'h44, 2'd0, 1'b1);
    check("pp_head_44", bus.data_o, 8'h44);
    step(1'b1, 8'h55, 2'd1, 1'b1);
    check("pp_data_55", bus.data_o, 8'h55);
    check("pp_valid", bus.valid_o, 1'b1);
    check("pp_ready", bus.ready_o, 1'b1);
    step(1'b0, 8'h00, 2'd0, 1'b1);

    // Reset with two entries buffered; coinciding push/pop must be discarded.
    step(1'b1, 8'hA1, 2'd0, 1'b0);
    step(1'b1, 8'hA2, 2'd0, 1'b0);
    check("mid_full", bus.ready_o, 1'b0);
    rst = 1'b1;
    bus.data_i  = 8'hA3;
    bus.ready_i = 1'b1;
    #1;
    check("mid_ready_in_rst", bus.ready_o, 1'b0);
    step(1'b1, 8'hA3, 2'd0, 1'b1);
    check("mid_valid_cleared", bus.valid_o, 1'b0);
    check("mid_count_cleared", bus.count_o, 0);
    check("mid_ready_still_low", bus.ready_o, 1'b0);
    rst = 1'b0;
    bus.valid_i = 1'b0;
    #1;
    check("mid_ready_after", bus.ready_o, 1'b1);
    step(1'b1, 8'h66, 2'd3, 1'b1);
    check("mid_data_66", bus.data_o, 8'h66);
    check("mid_sel_66", bus.sel_o, 2'd3);
    step(1'b0, 8'h00, 2'd0, 1'b1);
    check("mid_alone", bus.valid_o, 1'b0);

    // Counter saturation.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'(i + 1), 2'(i), 1'b1);
      check("sat_count", bus.count_o, (i + 1 < CNT_MAX) ? i + 1 : CNT_MAX);
    end
    step(1'b0, 8'h00, 2'd0, 1'b1);
    check("sat_hold", bus.count_o, 15);

    repeat (2) step(1'b0, 8'h00, 2'd0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
